// File: rtl/serial_subtractor_pkg.sv
// Definitions shared by the bit-serial arithmetic blocks: FSM state encoding
// and the signed-overflow rule applied to the operand and result sign bits.
package serial_subtractor_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serial_state_e;

  localparam int unsigned DEF_WIDTH = 8;

  // Subtraction overflows only when the operand signs differ and the result
  // sign disagrees with the minuend sign.
  function automatic logic sub_signed_ovf(input logic a_msb,
                                          input logic b_msb,
                                          input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic diff_ab_s;

  assign diff_ab_s = a ^ b;
  assign d         = diff_ab_s ^ bin;
  assign bout      = (~a & b) | (~diff_ab_s & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b computed LSB first, one bit per clock,
// using a single full-subtractor cell and a borrow flip-flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  serial_state_e    state_r;
  serial_state_e    state_nxt_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_ff_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             busy_r;
  logic             done_r;
  logic             borrow_r;
  logic             ovf_r;
  logic             d_s;
  logic             bout_s;
  logic             accept_s;
  logic             last_s;

  full_subtractor u_fs (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (borrow_ff_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // Next-state decode: accept a request in IDLE, leave SHIFT on the last bit.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_r == CNT_LAST) begin
          last_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand/result shift registers, bit counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= '0;
      a_sh_r      <= '0;
      b_sh_r      <= '0;
      res_sh_r    <= '0;
      diff_r      <= '0;
      borrow_ff_r <= 1'b0;
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      borrow_r    <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      done_r <= last_s;
      if (accept_s) begin
        a_sh_r      <= a;
        b_sh_r      <= b;
        a_msb_r     <= a[WIDTH-1];
        b_msb_r     <= b[WIDTH-1];
        borrow_ff_r <= 1'b0;
        cnt_r       <= '0;
        busy_r      <= 1'b1;
      end else if (state_r == ST_SHIFT) begin
        a_sh_r      <= {1'b0, a_sh_r[WIDTH-1:1]};
        b_sh_r      <= {1'b0, b_sh_r[WIDTH-1:1]};
        res_sh_r    <= {d_s, res_sh_r[WIDTH-1:1]};
        borrow_ff_r <= bout_s;
        if (last_s) begin
          // Publish only the completed result; partial bits stay internal.
          diff_r   <= {d_s, res_sh_r[WIDTH-1:1]};
          borrow_r <= bout_s;
          ovf_r    <= sub_signed_ovf(a_msb_r, b_msb_r, d_s);
          busy_r   <= 1'b0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign diff   = diff_r;
  assign borrow = borrow_r;
  assign ovf    = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operations at
// WIDTH=8, plus an exhaustive back-to-back sweep at WIDTH=4.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, busy8, done8, borrow8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, busy4, done4, borrow4, ovf4;
  logic [3:0] a4, b4, diff4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .ovf(ovf4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic logic [31:0] m_diff(int a, int b, int w);
    return 32'((a - b) & ((1 << w) - 1));
  endfunction

  function automatic logic m_borrow(int a, int b);
    return (a < b);
  endfunction

  function automatic logic m_ovf(int a, int b, int w);
    int half, sa, sb, r;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - (1 << w) : a;
    sb = (b >= half) ? b - (1 << w) : b;
    r  = sa - sb;
    return (r < -half) || (r > half - 1);
  endfunction

  task automatic wait_done8(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done8 !== 1'b1 && cyc < 40);
  endtask

  task automatic wait_done4(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done4 !== 1'b1 && cyc < 40);
  endtask

  task automatic check_res8(input string tag, input int a, input int b);
    check({tag, "_diff"},   diff8,   m_diff(a, b, 8));
    check({tag, "_borrow"}, borrow8, m_borrow(a, b));
    check({tag, "_ovf"},    ovf8,    m_ovf(a, b, 8));
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b);
    int cyc;
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check({tag, "_busy"}, busy8, 1'b1);
    wait_done8(cyc);
    check({tag, "_lat"}, cyc, 8);
    check_res8(tag, a, b);
    @(negedge clk);
    check({tag, "_done_pulse"}, done8, 1'b0);
    check({tag, "_hold"}, diff8, m_diff(a, b, 8));
  endtask

  initial begin
    int cyc, cnt, ea, eb, na, nb;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start4 = 1'b0; a4 = 4'h0;  b4 = 4'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_diff", diff8, 8'h00);
    check("rst_borrow", borrow8, 1'b0);
    check("rst_ovf", ovf8, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run8("d05_03", 8'h05, 8'h03);
    run8("d03_05", 8'h03, 8'h05);
    run8("d00_00", 8'h00, 8'h00);
    run8("d80_01", 8'h80, 8'h01);
    run8("d7f_ff", 8'h7F, 8'hFF);

    // Start pulsed mid-operation must be ignored.
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      cyc++;
      check("ign_busy", busy8, 1'b1);
      check("ign_hold_prev", diff8, 8'h80);
    end
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk);
    cyc++;
    start8 = 1'b0;
    check("ign_busy2", busy8, 1'b1);
    do begin
      @(negedge clk);
      cyc++;
      if (done8 !== 1'b1) check("ign_hold_prev2", diff8, 8'h80);
    end while (done8 !== 1'b1 && cyc < 40);
    check("ign_lat", cyc, 8);
    check_res8("ign", 8'h10, 8'h01);
    @(negedge clk);
    check("ign_idle_busy", busy8, 1'b0);
    check("ign_idle_done", done8, 1'b0);

    // Reset in the middle of an operation.
    a8 = 8'h22; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", busy8, 1'b0);
    check("mrst_done", done8, 1'b0);
    check("mrst_diff", diff8, 8'h00);
    check("mrst_borrow", borrow8, 1'b0);
    check("mrst_ovf", ovf8, 1'b0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8 === 1'b1) cnt++;
    end
    check("mrst_no_done", cnt, 0);
    run8("mrst_after", 8'h9C, 8'h3A);

    // Random single operations.
    for (int i = 0; i < 10; i++) begin
      run8("rnd", 8'($urandom_range(255)), 8'($urandom_range(255)));
    end

    // Start held high: back-to-back operations every WIDTH+1 cycles.
    ea = int'($urandom_range(255)); eb = int'($urandom_range(255));
    a8 = 8'(ea); b8 = 8'(eb); start8 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_done8(cyc);
      check("b2b8_period", cyc, 9);
      check_res8("b2b8", ea, eb);
      if (k < 5) begin
        na = int'($urandom_range(255)); nb = int'($urandom_range(255));
        a8 = 8'(na); b8 = 8'(nb);
        ea = na; eb = nb;
      end else begin
        start8 = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b8_idle", busy8, 1'b0);

    // WIDTH=4 exhaustive sweep with start held high.
    a4 = 4'h0; b4 = 4'h0; start4 = 1'b1;
    for (int idx = 0; idx < 256; idx++) begin
      wait_done4(cyc);
      check("w4_period", cyc, 5);
      check("w4_diff",   diff4,   m_diff(idx / 16, idx % 16, 4));
      check("w4_borrow", borrow4, m_borrow(idx / 16, idx % 16));
      check("w4_ovf",    ovf4,    m_ovf(idx / 16, idx % 16, 4));
      if (idx < 255) begin
        a4 = 4'((idx + 1) / 16);
        b4 = 4'((idx + 1) % 16);
      end else begin
        start4 = 1'b0;
      end
    end
    @(negedge clk);
    check("w4_idle", busy4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
